// File: rtl/reg_file.sv
// KGP_RISC architectural register file: 32x32 flops, two forwarded read
// ports, and a valid/ready dump engine that streams all registers in order.
module reg_file #(
  parameter int NREGS = 32,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             RegWrite,
  input  logic [4:0]       wrA,
  input  logic [WIDTH-1:0] wrD,
  input  logic [4:0]       rsA,
  input  logic [4:0]       rtA,
  output logic [WIDTH-1:0] rs,
  output logic [WIDTH-1:0] rt,
  input  logic             dump_req,
  input  logic             dump_ready,
  output logic             dump_valid,
  output logic [4:0]       dump_addr,
  output logic [WIDTH-1:0] dump_data,
  output logic             dump_busy,
  output logic             dump_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_e;

  logic [WIDTH-1:0] regs_q [NREGS];

  state_e           state_q, state_d;
  logic [4:0]       idx_q, idx_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             busy_q;
  logic [4:0]       cap_a;
  logic [WIDTH-1:0] cap_v;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (RegWrite) begin
      regs_q[wrA] <= wrD;
    end
  end

  assign rs = (RegWrite && wrA == rsA) ? wrD : regs_q[rsA];
  assign rt = (RegWrite && wrA == rtA) ? wrD : regs_q[rtA];

  // Beat capture sees a write committing on the same edge.
  assign cap_a = (state_q == IDLE) ? 5'd0 : idx_q + 5'd1;
  assign cap_v = (RegWrite && wrA == cap_a) ? wrD : regs_q[cap_a];

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    unique case (state_q)
      IDLE: begin
        if (dump_req) begin
          state_d = SEND;
          idx_d   = 5'd0;
          data_d  = cap_v;
        end
      end
      SEND: begin
        if (dump_ready) begin
          if (idx_q == 5'd31) begin
            state_d = DONE;
          end else begin
            idx_d  = cap_a;
            data_d = cap_v;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      busy_q  <= (state_d == SEND);
    end
  end

  assign dump_valid = (state_q == SEND);
  assign dump_done  = (state_q == DONE);
  assign dump_busy  = busy_q;
  assign dump_addr  = idx_q;
  assign dump_data  = data_q;

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: reset, write/read, forwarding, dump,
// backpressure with concurrent writes, and reset mid-dump.
module tb_reg_file;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWrite;
  logic [4:0]  wrA;
  logic [31:0] wrD;
  logic [4:0]  rsA;
  logic [4:0]  rtA;
  logic [31:0] rs;
  logic [31:0] rt;
  logic        dump_req;
  logic        dump_ready;
  logic        dump_valid;
  logic [4:0]  dump_addr;
  logic [31:0] dump_data;
  logic        dump_busy;
  logic        dump_done;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  reg_file #(.NREGS(32), .WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .RegWrite   (RegWrite),
    .wrA        (wrA),
    .wrD        (wrD),
    .rsA        (rsA),
    .rtA        (rtA),
    .rs         (rs),
    .rt         (rt),
    .dump_req   (dump_req),
    .dump_ready (dump_ready),
    .dump_valid (dump_valid),
    .dump_addr  (dump_addr),
    .dump_data  (dump_data),
    .dump_busy  (dump_busy),
    .dump_done  (dump_done)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    RegWrite = 1'b1;
    wrA      = a;
    wrD      = d;
    step();
    RegWrite = 1'b0;
  endtask

  int done_cnt;
  int cyc;

  initial begin
    rst        = 1'b1;
    RegWrite   = 1'b0;
    wrA        = '0;
    wrD        = '0;
    rsA        = '0;
    rtA        = '0;
    dump_req   = 1'b0;
    dump_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    rsA = 5'd5;
    rtA = 5'd31;
    #1;
    check("rst_rs", rs, 32'h0);
    check("rst_rt", rt, 32'h0);
    check("rst_valid", {31'h0, dump_valid}, 32'h0);
    check("rst_busy", {31'h0, dump_busy}, 32'h0);
    check("rst_done", {31'h0, dump_done}, 32'h0);
    check("rst_addr", {27'h0, dump_addr}, 32'h0);
    check("rst_data", dump_data, 32'h0);

    wr(5'd7, 32'hDEADBEEF);
    rsA = 5'd7;
    #1;
    check("wr_r7", rs, 32'hDEADBEEF);
    wr(5'd0, 32'h1);
    rsA = 5'd0;
    #1;
    check("wr_r0", rs, 32'h1);

    wr(5'd3, 32'h11);
    RegWrite = 1'b1;
    wrA      = 5'd3;
    wrD      = 32'h22;
    rsA      = 5'd3;
    rtA      = 5'd3;
    #1;
    check("fwd_rs", rs, 32'h22);
    check("fwd_rt", rt, 32'h22);
    RegWrite = 1'b0;
    #1;
    check("nofwd_rs", rs, 32'h11);
    check("nofwd_rt", rt, 32'h11);

    for (int i = 0; i < 32; i++) wr(5'(i), 32'(i) * 32'h100);
    dump_ready = 1'b1;
    dump_req   = 1'b1;
    step();
    dump_req = 1'b0;
    for (int i = 0; i < 32; i++) begin
      check($sformatf("dump_v%0d", i), {31'h0, dump_valid}, 32'h1);
      check($sformatf("dump_a%0d", i), {27'h0, dump_addr}, 32'(i));
      check($sformatf("dump_d%0d", i), dump_data, 32'(i) * 32'h100);
      check($sformatf("dump_b%0d", i), {31'h0, dump_busy}, 32'h1);
      step();
    end
    check("done_pulse", {31'h0, dump_done}, 32'h1);
    check("done_valid", {31'h0, dump_valid}, 32'h0);
    check("done_busy", {31'h0, dump_busy}, 32'h0);
    step();
    check("done_clear", {31'h0, dump_done}, 32'h0);
    check("idle_busy", {31'h0, dump_busy}, 32'h0);

    dump_req = 1'b1;
    step();
    dump_req = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("bp_addr4", {27'h0, dump_addr}, 32'h4);
    check("bp_data4", dump_data, 32'h400);
    dump_ready = 1'b0;
    wr(5'd4, 32'hAAAA);
    check("bp_hold_a", {27'h0, dump_addr}, 32'h4);
    check("bp_hold_d", dump_data, 32'h400);
    check("bp_hold_v", {31'h0, dump_valid}, 32'h1);
    dump_ready = 1'b1;
    wr(5'd5, 32'hBBBB);
    check("bp_addr5", {27'h0, dump_addr}, 32'h5);
    check("bp_data5", dump_data, 32'hBBBB);
    done_cnt = 0;
    cyc      = 0;
    while (done_cnt == 0 && cyc < 40) begin
      if (dump_done) done_cnt++;
      step();
      cyc++;
    end
    check("bp_done_seen", 32'(done_cnt), 32'h1);

    dump_req = 1'b1;
    step();
    dump_req = 1'b0;
    for (int i = 0; i < 10; i++) step();
    check("mid_addr10", {27'h0, dump_addr}, 32'd10);
    rst      = 1'b1;
    RegWrite = 1'b1;
    wrA      = 5'd9;
    wrD      = 32'h55;
    step();
    RegWrite = 1'b0;
    check("mid_valid", {31'h0, dump_valid}, 32'h0);
    check("mid_busy", {31'h0, dump_busy}, 32'h0);
    check("mid_done", {31'h0, dump_done}, 32'h0);
    check("mid_addr", {27'h0, dump_addr}, 32'h0);
    check("mid_data", dump_data, 32'h0);
    rst = 1'b0;
    rsA = 5'd31;
    rtA = 5'd4;
    #1;
    check("mid_rs31", rs, 32'h0);
    check("mid_rt4", rt, 32'h0);
    rsA = 5'd9;
    #1;
    check("rst_wr_drop", rs, 32'h0);
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (dump_done || dump_valid) done_cnt++;
      step();
    end
    check("mid_no_done", 32'(done_cnt), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/reg_file.md
# reg_file

Architectural register file for the KGP_RISC core, sitting directly downstream of the write-back select stage. It consumes the write-back triple (`RegWrite`, `wrA`, `wrD`), commits it on the clock edge, and serves two operand read ports to decode/execute with same-cycle write-to-read forwarding. It also includes a debug dump engine that streams all 32 registers, in order, over a valid/ready handshake, for bench and board inspection.

## Interface
- `NREGS`, 32: number of registers; fixed to 32 (5-bit addresses).
- `WIDTH`, 32: register width in bits.

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `RegWrite`  in  1  write enable from the write-back stage.
- `wrA`  in  5  write address; 31 is the return-address register.
- `wrD`  in  32  write data.
- `rsA`  in  5  read port A address.
- `rtA`  in  5  read port B address.
- `rs`  out  32  read port A data, combinational.
- `rt`  out  32  read port B data, combinational.
- `dump_req`  in  1  starts a register dump; level-sampled in IDLE.
- `dump_ready`  in  1  consumer accepts the current dump beat.
- `dump_valid`  out  1  dump beat present.
- `dump_addr`  out  5  index of the current beat.
- `dump_data`  out  32  value of the current beat.
- `dump_busy`  out  1  high in SEND.
- `dump_done`  out  1  one-cycle pulse after the final beat is accepted.

## Operation
- Storage is 32 x 32 flops. There is no hardwired zero: register 0 is writable like the others.
- Write: when `RegWrite`=1, `r[wrA]` takes `wrD` at the rising edge. When `RegWrite`=0, the array holds.
- Read: `rs` = (`RegWrite` && `wrA`==`rsA`) ? `wrD` : `r[rsA]`. `rt` uses the same rule. Forwarding applies to every address, including 0 and 31.
- Dump FSM states are IDLE, SEND and DONE.
  - IDLE: if `dump_req`=1, load index 0, capture beat, go to SEND.
  - SEND: `dump_valid`=1. A handshake occurs when `dump_valid` && `dump_ready`.
    - On a handshake with index < 31: increment the index and capture the next beat.
    - On a handshake with index = 31: go to DONE.
    - With no handshake: `dump_addr` and `dump_data` hold stable, even if the presented register is written meanwhile.
  - DONE: `dump_done`=1 for exactly one cycle, then IDLE unconditionally. `dump_req` is ignored in DONE and SEND.
- Beat capture at an edge: `dump_data` <= (`RegWrite` && `wrA`==idx) ? `wrD` : `r[idx]`. This means a write committing on the same edge is included.
- Writes and reads proceed normally during a dump; the dump never stalls the pipeline.
- Reset: all 32 registers go to 0 and the FSM goes to IDLE. `dump_valid`, `dump_busy`, `dump_done`, `dump_addr` and `dump_data` all go to 0.
  - A reset asserted mid-dump aborts it with no `dump_done` pulse.
  - A write presented in the reset cycle is discarded.
  - `rs` and `rt` reflect the zeroed array in the cycle after reset, with forwarding still active.

## Timing
- Write latency is 1 edge. Read latency is 0, combinational from address or write inputs.
- Dump start: `dump_req` sampled at edge t gives `dump_valid`=1 with addr 0 after t.
- With `dump_ready` held at 1, one beat is accepted per cycle. After edge t:
  - beats occupy cycles t+1 through t+32;
  - `dump_done` is high in cycle t+33;
  - the FSM is back in IDLE at t+34, where a new `dump_req` can be accepted.
- `dump_busy` equals state==SEND and is registered.

## Test plan
- Reset then read: with `rst` high for 2 cycles then low, `rsA`=5 and `rtA`=31 → `rs`=0, `rt`=0, and all dump outputs are 0.
- Write then read: `RegWrite`=1, `wrA`=7, `wrD`=0xDEADBEEF for one cycle, then `RegWrite`=0 with `rsA`=7 → `rs`=0xDEADBEEF. Writing `wrA`=0 with 0x1 → `rsA`=0 reads 0x1.
- Forwarding: hold `r[3]`=0x11, then in one cycle drive `RegWrite`=1, `wrA`=3, `wrD`=0x22, `rsA`=`rtA`=3 → `rs`=`rt`=0x22 in that same cycle. In the same cycle with `RegWrite`=0 → 0x11.
- Full dump: preload `r[i]`=i*0x100, pulse `dump_req`, hold `dump_ready`=1 → 32 consecutive beats with addr 0..31 and data 0x000..0x1F00, then one `dump_done` pulse, then `dump_busy`=0.
- Backpressure with concurrent write: during a dump, drop `dump_ready` while addr=4 is presented, write `r[4]`=0xAAAA and `r[5]`=0xBBBB, then raise `dump_ready` → beat 4 stays at its old value, and beat 5 = 0xBBBB.
- Reset mid-dump: assert `rst` while addr=10 is presented → next cycle `dump_valid`=0, `dump_busy`=0, `dump_done` never pulses, and `rs` for any address is 0.
